// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_ctrl
// Purpose  : EX-stage forward selects and load-use interlock, driven from a
//            private EX/MEM/WB destination shadow. Define HAZARD_STATS_EN to
//            add the saturating stall_count output.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl #(
   parameter int REG_W       = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush,
   output logic [1:0]       ForwardA_signal,
   output logic [1:0]       ForwardB_signal,
   output logic             stall,
   output logic             bubble
`ifdef HAZARD_STATS_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_count
`endif
);

   typedef struct packed {
      logic             valid;
      logic             regwrite;
      logic [REG_W-1:0] rd;
   } dst_t;

   typedef struct packed {
      dst_t             dst;
      logic             memread;
      logic             rs_used;
      logic             rt_used;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
   } ex_t;

   if (REG_W < 1 || STALL_CNT_W < 1) begin : g_param_check
      $error("hazard_forward_ctrl: REG_W and STALL_CNT_W must be positive");
   end

   ex_t  ex_q,  ex_d;
   dst_t mem_q, mem_d;
   dst_t wb_q,  wb_d;

   logic load_use;

   function automatic logic writes(input dst_t s, input logic [REG_W-1:0] r);
      return s.valid && s.regwrite && (s.rd == r) && (s.rd != '0);
   endfunction

   // Newest producer wins: MEM is checked before WB.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] r,
                                          input dst_t mem, input dst_t wb);
      if (used && writes(mem, r))
         return 2'b10;
      else if (writes(wb, r))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      ForwardA_signal = 2'b00;
      ForwardB_signal = 2'b00;
      if (ex_q.dst.valid) begin
         ForwardA_signal = fwd_sel(ex_q.rs_used, ex_q.rs, mem_q, wb_q);
         ForwardB_signal = fwd_sel(ex_q.rt_used, ex_q.rt, mem_q, wb_q);
      end
   end

   always_comb begin
      load_use = id_valid && ex_q.dst.valid && ex_q.memread && (ex_q.dst.rd != '0) &&
                 ((id_rs_used && (id_rs == ex_q.dst.rd)) ||
                  (id_rt_used && (id_rt == ex_q.dst.rd)));
      // Outputs are forced low for as long as reset is held.
      stall  = !reset && load_use && !flush;
      bubble = !reset && (load_use || flush);
   end

   always_comb begin
      ex_d = '0;
      if (id_valid && !bubble && !flush) begin
         ex_d.dst.valid    = 1'b1;
         ex_d.dst.regwrite = id_regwrite;
         ex_d.dst.rd       = id_rd;
         ex_d.memread      = id_memread;
         ex_d.rs_used      = id_rs_used;
         ex_d.rt_used      = id_rt_used;
         ex_d.rs           = id_rs;
         ex_d.rt           = id_rt;
      end
      mem_d = ex_q.dst;
      wb_d  = mem_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

`ifdef HAZARD_STATS_EN
   logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1))
         stall_count_d = stall_count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_count_q <= '0;
      else
         stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

- Sequencing controller for the EX-stage operand forwarding muxes and the load-use interlock of the five-stage pipeline.
- Keeps its own shadow of the destination-register state of the EX, MEM and WB stages.
- From that shadow it drives the 2-bit forward selects for operand A and operand B in EX. It also stalls PC/IF-ID and injects a bubble into ID/EX on a load-use hazard.
- Sits beside the ID/EX boundary and follows every pipeline advance, so it needs no external copy of the pipeline registers.

## Interface
Parameters:
- REG_W, 5, register-index width
- STALL_CNT_W, 16, width of the optional stall counter

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  the instruction in ID is real (not a bubble)
- id_rs  in  REG_W  source register 1 of the ID instruction
- id_rt  in  REG_W  source register 2 of the ID instruction
- id_rs_used  in  1  the ID instruction reads rs
- id_rt_used  in  1  the ID instruction reads rt
- id_rd  in  REG_W  final destination register of the ID instruction (after the RegDst mux)
- id_regwrite  in  1  the ID instruction writes the register file
- id_memread  in  1  the ID instruction is a load
- flush  in  1  branch/jump taken; the ID instruction is squashed
- ForwardA_signal  out  2  operand A select in EX: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB write data
- ForwardB_signal  out  2  operand B select, same encoding
- stall  out  1  hold PC and IF/ID this cycle
- bubble  out  1  zero the ID/EX control fields this cycle
- stall_count  out  STALL_CNT_W  present only with HAZARD_STATS_EN

## Operation
- Internal slots: EX, MEM and WB.
  - Each slot holds {valid, rd, regwrite, memread}.
  - The EX slot also holds {rs, rt, rs_used, rt_used}.
- Every clock: WB←MEM, MEM←EX, EX←ID entry.
  - The ID entry becomes a bubble (valid=0, all other fields 0) when bubble=1, flush=1 or id_valid=0.
- A slot "writes r" when valid & regwrite & rd==r & rd!=0.
  - Register 0 is never forwarded and never causes a stall.
- ForwardA_signal:
  - 10 if EX.rs_used and MEM writes EX.rs;
  - otherwise 01 if WB writes EX.rs;
  - otherwise 00.
- ForwardB_signal: same rule using rt.
- MEM has priority over WB when both match; the newest value wins.
- Encoding 11 is never driven.
- When the EX slot is invalid, both selects are 00.
- Load-use hazard:
  - Condition: id_valid & EX.valid & EX.memread & EX.rd!=0 & ((id_rs_used & id_rs==EX.rd) | (id_rt_used & id_rt==EX.rd)).
  - Response: stall=1 and bubble=1.
- flush has priority: when flush=1, stall=0 and bubble=1. The squashed instruction never creates a hazard.
- A load in MEM or WB never stalls; its data is forwarded through 01.

## Timing
- Reset (asynchronous) clears all slots to invalid/zero.
  - ForwardA_signal=00, ForwardB_signal=00, stall=0, bubble=0, stall_count=0.
  - These values hold while reset=1.
- Forward selects are a combinational function of registered slots only. They are valid shortly after the clock edge, with no path from ID inputs.
- stall and bubble are combinational from the ID inputs and the EX slot, within the same cycle.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load is in MEM with a bubble in EX, so the re-presented instruction sees no hazard. After the following edge it reaches EX with its select = 01.
- Back-to-back loads, each followed by a dependent instruction, stall once per pair.
- Deassertion of reset mid-stream: slots start empty, so no forwarding happens until real instructions have advanced.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count port exists.
  - It is a STALL_CNT_W-bit counter that increments on every cycle with stall=1.
  - It saturates at all-ones and clears on reset.
- HAZARD_STATS_EN undefined: no stall_count port and no counter logic. All other behaviour is identical.

## Test plan
- Two back-to-back ALU ops: add r3 (rd=3, regwrite) followed by sub using rs=3. The cycle the sub is in EX → ForwardA_signal=10, stall=0.
- Producer writes r5, then one independent instruction, then a consumer with rt=5 → ForwardB_signal=01 when the consumer is in EX.
- Consecutive writes to r7, then a consumer with rs=7 → 10 (MEM wins over WB).
- Load r4 (memread=1), next instruction reads rs=4:
  - stall=1 and bubble=1 for exactly 1 cycle;
  - consumer then reaches EX with ForwardA_signal=01;
  - with HAZARD_STATS_EN, stall_count=1.
- Load-use hazard coincident with flush=1 → stall=0, bubble=1, and no later forward from the squashed instruction.
- Writes to r0 followed by reads of r0 produce only 00 selects and no stall. Asserting reset mid-stream forces all outputs to 0 immediately.
